// File: rtl/cond_branch_unit.sv
// Conditional/unconditional branch resolver with flag forwarding, registered PC redirect,
// timed pipeline flush and saturating branch statistics.
module cond_branch_unit #(
  parameter int ADDR_W       = 64,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic              is_uncond,
  input  logic              is_cbz,
  input  logic              is_bcond,
  input  logic [3:0]        cond,
  input  logic              reg_zero,
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       br_offset,
  input  logic              zero,
  input  logic              negative,
  input  logic              overflow,
  input  logic              carryout,
  input  logic              ex_flagWrite,
  input  logic              ex_zero,
  input  logic              ex_negative,
  input  logic              ex_overflow,
  input  logic              ex_carryout,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              busy,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, REDIRECT = 2'd1, FLUSH = 2'd2} state_t;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : {FC_W{1'b0}};
  localparam bit HAS_FLUSH = (FLUSH_CYCLES > 0);

  // Condition codes come in complementary pairs: bits [3:1] pick the test, bit 0 inverts it,
  // except the top pair which is always true.
  function automatic logic cond_true(input logic [3:0] c, input logic z, input logic n,
                                     input logic v, input logic cy);
    logic base;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      3'd7:    base = 1'b1;
      default: base = 1'b0;
    endcase
    if (c[3:1] == 3'd7) begin
      return 1'b1;
    end else begin
      return base ^ c[0];
    end
  endfunction

  state_t              state_r, state_next_s;
  logic [FC_W-1:0]     flush_cnt_r;
  logic                redirect_r, flush_r, busy_r;
  logic [ADDR_W-1:0]   redirect_pc_r;
  logic [CNT_W-1:0]    br_count_r, taken_count_r;
  logic                z_s, n_s, v_s, c_s;
  logic                taken_s, accept_s;
  logic [ADDR_W-1:0]   off_ext_s, target_s;

  // Effective flags, branch decision and target.
  always_comb begin
    z_s = zero;
    n_s = negative;
    v_s = overflow;
    c_s = carryout;
    if (ex_flagWrite) begin
      z_s = ex_zero;
      n_s = ex_negative;
      v_s = ex_overflow;
      c_s = ex_carryout;
    end else begin
      z_s = zero;
      n_s = negative;
      v_s = overflow;
      c_s = carryout;
    end
    if (is_uncond) begin
      taken_s = 1'b1;
    end else if (is_cbz) begin
      taken_s = reg_zero;
    end else if (is_bcond) begin
      taken_s = cond_true(cond, z_s, n_s, v_s, c_s);
    end else begin
      taken_s = 1'b0;
    end
    accept_s  = br_valid & (state_r == IDLE);
    off_ext_s = ADDR_W'($signed(br_offset));
    target_s  = pc + {off_ext_s[ADDR_W-3:0], 2'b00};
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && taken_s) begin
          state_next_s = REDIRECT;
        end else begin
          state_next_s = IDLE;
        end
      end
      REDIRECT: begin
        if (HAS_FLUSH) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == {FC_W{1'b0}}) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FLUSH;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, flush down-counter and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      flush_cnt_r <= {FC_W{1'b0}};
      redirect_r  <= 1'b0;
      flush_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      redirect_r <= (state_next_s == REDIRECT);
      flush_r    <= (state_next_s != IDLE);
      busy_r     <= (state_next_s != IDLE);
      if (state_r == REDIRECT) begin
        flush_cnt_r <= FC_LOAD;
      end else if ((state_r == FLUSH) && (flush_cnt_r != {FC_W{1'b0}})) begin
        flush_cnt_r <= flush_cnt_r - FC_W'(1);
      end
    end
  end

  // Redirect target capture and saturating statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_pc_r <= {ADDR_W{1'b0}};
      br_count_r    <= {CNT_W{1'b0}};
      taken_count_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      if (br_count_r != {CNT_W{1'b1}}) begin
        br_count_r <= br_count_r + CNT_W'(1);
      end
      if (taken_s) begin
        redirect_pc_r <= target_s;
        if (taken_count_r != {CNT_W{1'b1}}) begin
          taken_count_r <= taken_count_r + CNT_W'(1);
        end
      end
    end
  end

  assign redirect    = redirect_r;
  assign redirect_pc = redirect_pc_r;
  assign flush       = flush_r;
  assign busy        = busy_r;
  assign br_count    = br_count_r;
  assign taken_count = taken_count_r;

endmodule

// File: doc/cond_branch_unit.md
Name: cond_branch_unit

Overview:
- Downstream consumer of the flag register in the pipelined CPU.
- Resolves conditional branches (B.cond) and CBZ, plus unconditional branches, using either stored flags or flags forwarded from the EX-stage ALU.
- Issues a registered PC redirect and a timed pipeline flush, and keeps saturating branch statistics.

Parameters:
- ADDR_W, 64, PC and target width.
- FLUSH_CYCLES, 1, cycles of flush asserted after the redirect cycle. 0 is legal.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- br_valid  in  1  a branch instruction is presented this cycle
- is_uncond  in  1  unconditional branch (B)
- is_cbz  in  1  compare-and-branch-if-zero
- is_bcond  in  1  conditional branch on flags
- cond  in  4  B.cond condition code
- reg_zero  in  1  CBZ operand register equals zero
- pc  in  ADDR_W  PC of the branch instruction
- br_offset  in  26  signed word offset, already aligned to the LSB
- zero, negative, overflow, carryout  in  1 each  stored flags from the flag register outputs
- ex_flagWrite  in  1  EX-stage instruction writes flags this cycle
- ex_zero, ex_negative, ex_overflow, ex_carryout  in  1 each  EX-stage ALU flags
- redirect  out  1  take redirect_pc this cycle
- redirect_pc  out  ADDR_W  branch target
- flush  out  1  squash younger pipeline stages
- busy  out  1  unit is not in IDLE; inputs are ignored
- br_count  out  CNT_W  accepted branches
- taken_count  out  CNT_W  taken branches

Behaviour:
- Reset is asynchronous. While reset is high and immediately after it:
  - state = IDLE.
  - redirect, flush and busy = 0.
  - redirect_pc, br_count and taken_count = 0.
  - Reset mid-REDIRECT or mid-FLUSH aborts the sequence immediately.
- A branch is accepted when br_valid=1 and state=IDLE. br_valid during busy is ignored and not counted.
- If more than one of is_uncond, is_cbz, is_bcond is set, priority is is_uncond > is_cbz > is_bcond. If none is set, the branch is accepted, counted and not taken.
- Effective flags (Z, N, V, C):
  - ex_flagWrite=1: the ex_* flags (forwarding).
  - ex_flagWrite=0: the stored flags.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 HS: C
  - 3 LO: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z & N==V
  - D LE: Z | N!=V
  - E, F: always true
- Taken when any of these holds:
  - is_uncond.
  - is_cbz & reg_zero.
  - is_bcond & condition true.
- Target = pc + (sign_extend(br_offset) << 2), computed modulo 2^ADDR_W, so wrap-around is silent.
- FSM states are IDLE, REDIRECT, FLUSH.
  - IDLE, accepted and taken: next state REDIRECT; target is registered into redirect_pc.
  - IDLE, not taken: stay IDLE with no outputs asserted.
  - REDIRECT: exactly one cycle, with redirect=1, flush=1, busy=1. Next state is FLUSH if FLUSH_CYCLES>0, else IDLE.
  - FLUSH: flush=1, busy=1, redirect=0. Lasts FLUSH_CYCLES cycles (down-counter), then IDLE.
- Latency: redirect is asserted in the cycle after acceptance. redirect_pc holds its value until the next taken branch.
- Counters:
  - br_count increments by 1 on each accepted branch.
  - taken_count increments by 1 on each taken branch, in the same cycle as acceptance.
  - Both saturate at all-ones and never wrap.
- Back-to-back: a taken branch presented in the first cycle after returning to IDLE is accepted normally.

Test Plan:
- Stored flags Z=1, ex_flagWrite=0, is_bcond, cond=0 (EQ), pc=0x1000, offset=4 -> next cycle redirect=1, redirect_pc=0x1010, flush=1; then one FLUSH cycle (flush=1, redirect=0); then busy=0. br_count=1, taken_count=1.
- Forwarding: stored Z=1, but ex_flagWrite=1 with ex_zero=0, cond=0 -> not taken, no redirect, br_count increments, taken_count does not.
- Signed condition: effective N=1, V=0, cond=B (LT) -> taken. Same flags with cond=A (GE) -> not taken. is_cbz with reg_zero=0 -> not taken.
- Negative offset: pc=0x0, offset=-1 -> redirect_pc=0xFFFF_FFFF_FFFF_FFFC. A second taken br_valid during REDIRECT/FLUSH is ignored and counters are unchanged.
- CNT_W=4: 20 taken branches -> br_count=taken_count=15, held there. FLUSH_CYCLES=0: busy lasts exactly one cycle.
- Assert reset during FLUSH -> flush, redirect, busy and both counters are 0 immediately, without waiting for a clock edge; the next taken branch behaves as after power-up.
